// File: rtl/button_onepulse_if.sv
// button_onepulse_if
//   Groups the push-button signals of button_onepulse.
//   btn_in    : raw, asynchronous, possibly bouncing button level
//   t         : registered single-cycle pulse per debounced press
//   btn_level : registered debounced button level
//   master : the side that owns the button and consumes the pulse/level
//   slave  : the conditioning stage itself
interface button_onepulse_if;
    logic btn_in;
    logic t;
    logic btn_level;

    modport master (output btn_in, input t, input btn_level);
    modport slave  (input btn_in, output t, output btn_level);
endinterface

// File: rtl/button_onepulse.sv
// button_onepulse
//   Synchronizes a raw push-button, debounces it with a stable-sample counter
//   and emits a single-cycle t pulse per debounced press, meant to drive the
//   t input of a toggle flip-flop. A debounced level is provided for LEDs.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus.btn_in : raw button (asynchronous, bouncing)
//   bus.t      : registered one-cycle pulse
//   bus.btn_level : registered debounced level
//
// Optional feature (macro BUTTON_AUTO_REPEAT_EN)
//   When defined, holding the button emits extra t pulses REPEAT_DELAY cycles
//   after the initial pulse and then every REPEAT_PERIOD cycles. When not
//   defined, exactly one pulse is emitted per press and the repeat logic is
//   absent.
module button_onepulse #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    button_onepulse_if.slave   bus
);

    // Parameter legality is checked at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
        $error("button_onepulse: DEBOUNCE_CYCLES out of range");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("button_onepulse: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             t_q;
    logic             level_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt;
    // Set once the first auto-repeat pulse has fired; selects which
    // interval (delay or period) the repeat counter is measuring.
    logic             rpt_armed;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s       <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            t_q     <= 1'b0;
            level_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
`endif
        end else begin
            // Two-flop synchronizer; only s feeds the FSM.
            s1  <= bus.btn_in;
            s   <= s1;
            t_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end

                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= PRESSED;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        t_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                PRESSED: begin
                    if (!s) begin
                        // Repeat counter is left untouched here: it freezes
                        // while the release is being debounced.
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end
`ifdef BUTTON_AUTO_REPEAT_EN
                    else if (!rpt_armed && rpt_cnt == RPT_DELAY_LAST) begin
                        t_q       <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_armed <= 1'b1;
                    end else if (rpt_armed && rpt_cnt == RPT_PERIOD_LAST) begin
                        t_q     <= 1'b1;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + CNT_W'(1);
                    end
`endif
                end

                RELEASE_WAIT: begin
                    if (s) begin
                        // Bounce during release: back to PRESSED, no pulse.
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_armed <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.t         = t_q;
    assign bus.btn_level = level_q;

endmodule

// File: doc/button_onepulse.md
# button_onepulse

Upstream conditioning stage for the toggle flip-flop. Synchronizes a raw, bouncing push-button input, debounces it with a stable-sample counter, and produces a single-cycle `t` pulse per debounced press that drives the `t` input of the toggle flip-flop directly. A debounced level output is provided for status LEDs.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical synchronized samples required to accept a level change. Legal range is 2 to 2^CNT_W-1.
- `CNT_W`, default 16: width of the debounce and repeat counters.
- `REPEAT_DELAY`, default 8: cycles in PRESSED before the first auto-repeat pulse. Used only with `BUTTON_AUTO_REPEAT_EN`. Minimum 2.
- `REPEAT_PERIOD`, default 4: cycles between subsequent auto-repeat pulses. Used only with `BUTTON_AUTO_REPEAT_EN`. Minimum 2.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_in`, input, 1: raw button. It is asynchronous to `clk` and may bounce.
- `t`, output, 1: registered one-cycle pulse. Connects to the toggle flip-flop `t`.
- `btn_level`, output, 1: registered debounced button level.

## Operation

- Synchronizer:
  - Two flops: `btn_in` → `s1` → `s`.
  - Only `s` is used by the logic.
- FSM states and transitions:
  - IDLE (level 0): if `s`=1, go to PRESS_WAIT with cnt=1. Otherwise stay.
  - PRESS_WAIT: if `s`=0, return to IDLE with cnt=0. If `s`=1 and cnt=DEBOUNCE_CYCLES-1, go to PRESSED; `btn_level`←1 and `t`←1 on this same edge. Otherwise cnt++.
  - PRESSED (level 1): if `s`=0, go to RELEASE_WAIT with cnt=1. Otherwise stay.
  - RELEASE_WAIT: if `s`=1, return to PRESSED with cnt=0. No pulse is emitted on this return. If `s`=0 and cnt=DEBOUNCE_CYCLES-1, go to IDLE with `btn_level`←0. Otherwise cnt++.
- `t` is high for exactly one cycle per IDLE→PRESSED path. It is never high on release.
- A bounce shorter than DEBOUNCE_CYCLES samples has no effect on `t` or `btn_level`.
- The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Reset:
  - On `rst_n`=0, effective immediately: `s1`=`s`=0, state=IDLE, cnt=0, repeat counter=0, `t`=0, `btn_level`=0.
  - A reset mid-press aborts any pending pulse.
  - If the button is still held after reset release, the full debounce runs again and one new pulse is emitted.

## Timing

- Press latency: number the first rising edge that samples `btn_in`=1 as edge 1. `t` and `btn_level` rise on edge DEBOUNCE_CYCLES+2, provided `btn_in` stays high. `t` falls on the next edge.
- Release latency: `btn_level` falls DEBOUNCE_CYCLES+2 edges after the first edge that samples `btn_in`=0.
- Pulses on `t` are never asserted on consecutive cycles.

## Configuration

- Macro: `BUTTON_AUTO_REPEAT_EN`.
- Defined:
  - While in PRESSED, the repeat counter counts cycles.
  - An extra `t` pulse is emitted REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while PRESSED holds.
  - Entering RELEASE_WAIT freezes the repeat counter; no pulse is emitted while in RELEASE_WAIT.
  - A return to PRESSED resumes counting. Leaving to IDLE, or reset, clears the counter.
- Undefined:
  - The repeat counter and its logic are absent.
  - Exactly one pulse is emitted per debounced press, regardless of hold time.

## Test plan

Defaults apply throughout (DEBOUNCE_CYCLES=4).

1. Reset: hold `rst_n`=0 with `btn_in`=1, then release → `t`=0 and `btn_level`=0 during reset. One `t` pulse follows, 6 edges after the first post-reset edge.
2. Clean press: raise `btn_in` and hold for 20 cycles → a single `t` pulse on edge 6, and `btn_level`=1 from edge 6. Feeding the toggle flip-flop, its `q` toggles exactly once.
3. Bounce rejection: drive `btn_in` with the pattern 1,1,0,1,1,1,0 (one cycle each), then 0 → `t` is never asserted and `btn_level` stays 0.
4. Release bounce: while held, drop `btn_in` for 2 cycles and restore it, then release cleanly → no extra `t` pulse. `btn_level` falls only 6 edges after the clean release.
5. Reset mid-debounce: assert `rst_n`=0 asynchronously between edges 3 and 4 of a press → `t` stays 0, and the state restarts from IDLE.
6. With `BUTTON_AUTO_REPEAT_EN`: hold the button for 30 cycles → pulses at edges 6, 14, 18, 22, 26, 30, and none after release.
